// File: rtl/idct_pkg.sv
// idct_pkg: shared constants, read-FSM state type and mode helper for the IDCT transpose path.
// Rev 1.0
`default_nettype none

package idct_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_4X4  = 2'b01;
  localparam logic [1:0] MODE_8X8  = 2'b10;

  localparam int TILE_SAMPLES = 64;
  localparam int TILE_LOG2    = 6;
  localparam int DEF_WIDTH_X  = 16;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_e;

  // Mode 11 is an alias of 8x8, so only 01 selects the 4x4 layout.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_4X4) ? MODE_4X4 : MODE_8X8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tp_bank64.sv
// tp_bank64: 64-entry simple dual-port RAM with a registered 1-cycle read and no array reset.
// Rev 1.0
`default_nettype none

module tp_bank64
  import idct_pkg::*;
#(
  parameter int WIDTH_X = DEF_WIDTH_X
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [TILE_LOG2-1:0] waddr,
  input  logic [WIDTH_X-1:0]   wdata,
  input  logic                 re,
  input  logic [TILE_LOG2-1:0] raddr,
  output logic [WIDTH_X-1:0]   rdata
);

  logic [WIDTH_X-1:0] mem [TILE_SAMPLES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/idct_tp_reader.sv
// idct_tp_reader: ping-pong transpose buffer; rows written in natural order, columns read permuted.
// Rev 1.0
`default_nettype none

module idct_tp_reader
  import idct_pkg::*;
#(
  parameter int WIDTH_X    = DEF_WIDTH_X,
  parameter int DEPTH_LOG2 = TILE_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH_X-1:0]  d_in,
  output logic                out_valid,
  output logic [1:0]          out_mode,
  output logic                out_last,
  output logic [WIDTH_X-1:0]  d_out
);

  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Transpose inside an 8x8 block, or inside each 16-sample 4x4 block.
  function automatic logic [5:0] perm(input logic [5:0] idx, input logic [1:0] m);
    if (m == MODE_4X4) begin
      return {idx[5:4], idx[1:0], idx[3:2]};
    end
    return {idx[2:0], idx[5:3]};
  endfunction

  // Write side
  logic [DEPTH_LOG2-1:0] wptr;
  logic                  wb;
  logic [1:0]            tmode [2];
  logic [1:0]            full;
  logic                  wr_acc;
  logic                  tile_done;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;

  // Read side
  rd_state_e             state;
  rd_state_e             state_nxt;
  logic [DEPTH_LOG2-1:0] k;
  logic [DEPTH_LOG2-1:0] k_nxt;
  logic                  rb;
  logic                  issue;
  logic                  issue_last;
  logic [DEPTH_LOG2-1:0] raddr;

  // Output pipeline
  logic                  v1;
  logic                  last1;
  logic [1:0]            mode1;
  logic                  sel1;
  logic [WIDTH_X-1:0]    bank_q [2];

  assign in_ready  = ~full[wb];
  assign wr_acc    = in_valid & in_ready & (mode_in != MODE_IDLE);
  assign tile_done = wr_acc & (wptr == PTR_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      wb       <= 1'b0;
      tmode[0] <= MODE_IDLE;
      tmode[1] <= MODE_IDLE;
    end else if (wr_acc) begin
      wptr <= wptr + PTR_ONE;
      if (wptr == '0) begin
        tmode[wb] <= norm_mode(mode_in);
      end
      if (wptr == PTR_LAST) begin
        wb <= ~wb;
      end
    end else if ((mode_in == MODE_IDLE) && (wptr != '0)) begin
      // Abort: the partial tile is simply overwritten by the next one.
      wptr <= '0;
    end
  end

  assign full_set = tile_done  ? (wb ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = issue_last ? (rb ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      full <= (full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RD_IDLE;
      k     <= '0;
      rb    <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (issue_last) begin
        rb <= ~rb;
      end
    end
  end

  // k=0 is issued in the same cycle full[rb] is first seen, so tiles chain with no gap.
  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      RD_IDLE: begin
        if (full[rb]) begin
          issue     = 1'b1;
          k_nxt     = k + PTR_ONE;
          state_nxt = RD_BUSY;
        end
      end
      RD_BUSY: begin
        issue = 1'b1;
        k_nxt = k + PTR_ONE;
        if (k == PTR_LAST) begin
          issue_last = 1'b1;
          state_nxt  = RD_IDLE;
        end
      end
      default: begin
        state_nxt = RD_IDLE;
      end
    endcase
  end

  assign raddr = perm(k, tmode[rb]);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tp_bank64 #(
      .WIDTH_X (WIDTH_X)
    ) u_bank (
      .clk   (clk),
      .we    (wr_acc && (wb == 1'(b))),
      .waddr (wptr),
      .wdata (d_in),
      .re    (issue && (rb == 1'(b))),
      .raddr (raddr),
      .rdata (bank_q[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      mode1 <= MODE_IDLE;
      sel1  <= 1'b0;
    end else begin
      v1    <= issue;
      last1 <= issue_last;
      mode1 <= tmode[rb];
      sel1  <= rb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_mode  <= MODE_IDLE;
      d_out     <= '0;
    end else begin
      out_valid <= v1;
      out_last  <= last1;
      if (v1) begin
        d_out    <= bank_q[sel1];
        out_mode <= mode1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/idct_tp_reader.md
Name: idct_tp_reader

Overview:
- Transpose buffer for the IDCT datapath. Rows are written in natural order, and columns are read out in transposed order.
- It is the read-side dual of the existing transpose write controller: that block permutes on write and reads sequentially, while this block writes sequentially and permutes on read.
- It sits between the row-IDCT output and the column-IDCT input.
- It uses two 64-entry ping-pong banks, so a continuous input stream is sustained with no bubbles.

Parameters:
- WIDTH_X, default 16: sample width in bits (signed two's complement).
- DEPTH_LOG2, default 6: log2 of the samples per tile. Fixed at 6; present for the package constant only.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mode_in  in  2  transform mode of the incoming samples: 01 = four 4x4 blocks per tile, 10 = one 8x8 block, 11 = treated as 10, 00 = idle/abort
- in_valid  in  1  d_in valid
- in_ready  out  1  block can accept d_in this cycle
- d_in  in  WIDTH_X  input sample, row-major order
- out_valid  out  1  d_out valid
- out_mode  out  2  mode of the tile currently on d_out
- out_last  out  1  marks the 64th output sample of a tile
- d_out  out  WIDTH_X  output sample, signed, transposed order

Behaviour:
- Reset (rst_n=0 at posedge):
  - in_ready=1, out_valid=0, out_last=0, out_mode=00, d_out=0.
  - wptr=0, rptr=0, wb=0, rb=0, full[1:0]=00, reading=0.
  - RAM contents are don't-care.
  - Reset mid-tile discards all buffered data; the first sample after reset starts a new tile in bank 0.
- Write side:
  - A write is accepted when in_valid & in_ready & mode_in!=00.
  - Each accepted write stores d_in at bank[wb][wptr], then wptr increments, wrapping 63->0.
  - On the first accepted sample of a tile (wptr=0), mode_in is latched into tmode[wb].
  - On the write with wptr=63, full[wb] is set and wb toggles.
  - in_ready = !full[wb], combinational from registers.
  - mode_in=00 with wptr!=0 aborts the partial tile: wptr<=0, the bank is not marked full, nothing else changes.
  - in_valid with mode_in=00 is never written.
- Read side:
  - When reading=0 and full[rb]=1: reading<=1 and k<=0.
  - While reading, one RAM read is issued per cycle at raddr=perm(k, tmode[rb]), and k increments.
  - After k=63 is issued: full[rb] clears, rb toggles, reading drops.
  - If full of the new rb is already set, the next tile starts on the very next cycle (k=0), so back-to-back tiles have no output gap.
- Permutation (k = 6-bit sequential index):
  - 8x8: raddr = {k[2:0], k[5:3]}.
  - 4x4: raddr = {k[5:4], k[1:0], k[3:2]}. The block index is kept and the transpose happens within each 16-sample block.
- Latency:
  - Synchronous RAM, 1-cycle read, plus an output register.
  - A read issued in cycle t gives d_out, out_valid=1 and the tile's out_mode in cycle t+2.
  - out_last=1 accompanies the sample issued at k=63.
  - out_valid=0 whenever no read was issued two cycles earlier. d_out holds its last value when invalid.
- Throughput:
  - With continuous input, the first sample of a tile accepted at T0 lands in bank A, and full[A] is set at the T0+64 edge.
  - Read k=0 is issued at T0+64, and the first d_out appears at T0+66.
  - Bank B fills during T0+64..T0+127 while A drains, and full[A] clears at the T0+128 edge.
  - As a result in_ready stays 1 indefinitely.
- Simultaneous events:
  - Set of full[wb] and clear of full[rb] in the same cycle is legal (different banks).
  - The same bank can never be set and cleared in one cycle, because in_ready gates the write.
  - Read and write of the same bank never overlap.

Decomposition:
- Shared package idct_pkg holds:
  - MODE_IDLE=2'b00, MODE_4X4=2'b01, MODE_8X8=2'b10
  - TILE_SAMPLES=64
  - WIDTH_X default
- One sub-module, tp_bank64: a 64xWIDTH_X simple dual-port RAM with write enable and address, read enable and address, 1-cycle registered read, and no reset on the array.
- Two instances of tp_bank64 are selected by wb/rb. The permutation is a small function inside idct_tp_reader.

Test Plan:
- 8x8 tile:
  - Stimulus: mode 10, d_in = 0..63 continuous.
  - Expect: d_out = 0,8,16,...,56,1,9,...,63.
  - Expect: first out_valid 66 cycles after the first accepted sample, out_last with 63, out_mode=10.
- 4x4 tile:
  - Stimulus: mode 01, d_in = 0..63.
  - Expect: d_out = 0,4,8,12,1,5,9,13,...,3,7,11,15,16,20,...,63, with out_mode=01.
- Back-to-back streaming:
  - Stimulus: 3 continuous tiles (8x8, 4x4, 8x8, values tile*64+i).
  - Expect: in_ready constantly 1, out_valid continuous for 192 cycles, 3 out_last pulses, out_mode switching at tile boundaries.
- Stall/fill:
  - Stimulus: two tiles written with in_valid gaps, then input frozen.
  - Expect: both tiles are output intact, and out_valid drops to 0 after 128 outputs.
- Abort:
  - Stimulus: 20 samples in mode 10, then one cycle of mode 00, then a full tile 100..163.
  - Expect: output is only the transposed 100..163 tile.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while a tile is being output.
  - Expect: the next cycle has out_valid=0, d_out=0, in_ready=1, and a fresh tile afterward transposes correctly.
